// File: rtl/e_mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or restoring-divide
// step per cycle, with multiply-accumulate/subtract and cancel on exception flush.
module e_mdu_iter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [OP_W-1:0]  mdu_op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             start,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MADD  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MADDU = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MSUB  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MSUBU = OP_W'(10);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   d1_raw;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic               is_div, acc_sub, neg_q, neg_r, div0;

  // Launch-time decode
  logic               op_arith, op_signed, op_div, op_acc, op_sub;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;

  always_comb begin
    op_arith  = 1'b0;
    op_signed = 1'b0;
    op_div    = 1'b0;
    op_acc    = 1'b0;
    op_sub    = 1'b0;
    case (mdu_op)
      OP_MULT:  begin op_arith = 1'b1; op_signed = 1'b1; end
      OP_MULTU: op_arith = 1'b1;
      OP_DIV:   begin op_arith = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
      OP_DIVU:  begin op_arith = 1'b1; op_div = 1'b1; end
      OP_MADD:  begin op_arith = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      OP_MADDU: begin op_arith = 1'b1; op_acc = 1'b1; end
      OP_MSUB:  begin op_arith = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      OP_MSUBU: begin op_arith = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      default:  ;
    endcase
    a_neg = op_signed & d1[WIDTH-1];
    b_neg = op_signed & d2[WIDTH-1];
    mag_a = a_neg ? -d1 : d1;
    mag_b = b_neg ? -d2 : d2;
  end

  // Shared product/remainder register: multiply shifts right accumulating into the
  // upper half; divide shifts left with the remainder in the upper half.
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod_next;

  always_comb begin
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? opnd : '0)};
    rem_sh  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd};
    if (!is_div)
      prod_next = {mul_sum, prod[WIDTH-1:1]};
    else if (diff[WIDTH])
      prod_next = {rem_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    else
      prod_next = {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] sprod, mul_res, div_res;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    sprod   = neg_q ? -prod : prod;
    mul_res = acc_sub ? (acc - sprod) : (acc + sprod);
    quo     = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem     = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    div_res = div0 ? {d1_raw, {WIDTH{1'b1}}} : {rem, quo};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      opnd    <= '0;
      d1_raw  <= '0;
      acc     <= '0;
      prod    <= '0;
      is_div  <= 1'b0;
      acc_sub <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !cancel && op_arith) begin
            state   <= S_CALC;
            cnt     <= CW'(WIDTH-1);
            opnd    <= op_div ? mag_b : mag_a;
            prod    <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
            d1_raw  <= d1;
            acc     <= op_acc ? {hi, lo} : '0;
            is_div  <= op_div;
            acc_sub <= op_sub;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            div0    <= op_div && (d2 == '0);
          end else if (!start && !cancel) begin
            if (mdu_op == OP_MTHI) hi <= d1;
            if (mdu_op == OP_MTLO) lo <= d1;
          end
        end
        S_CALC: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            prod <= prod_next;
            if (cnt == '0) state <= S_FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!cancel) {hi, lo} <= is_div ? div_res : mul_res;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_e_mdu_iter.sv
// Self-checking bench for e_mdu_iter (WIDTH=32): vector table plus hand-written
// sequences for reset, cancel, busy-time ignores and back-to-back accumulate.
module tb_e_mdu_iter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  mdu_op;
  logic [31:0] d1, d2;
  logic        start, cancel;
  logic        busy;
  logic [31:0] hi, lo;

  e_mdu_iter #(.WIDTH(32), .OP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .mdu_op(mdu_op), .d1(d1), .d2(d2),
    .start(start), .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] ihi, ilo, a, b, ehi, elo;
  } vec_t;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] l;
  } res_t;

  vec_t vt[13];
  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic mt(input bit is_hi, input logic [31:0] v);
    mdu_op = is_hi ? 4'd5 : 4'd6;
    d1 = v;
    @(negedge clk);
    mdu_op = 4'd0;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] eh, input logic [31:0] el);
    res_t r;
    mdu_op = op; d1 = a; d2 = b; start = 1'b1;
    if (push) begin
      r.h = eh; r.l = el;
      sb.push_back(r);
    end
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    d1 = $urandom; d2 = $urandom;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int   n;
    res_t r;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_lat"}, n, exp_lat);
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_sb: got empty scoreboard expected one entry", name);
    end else begin
      r = sb.pop_front();
      check({name, "_hi"}, hi, r.h);
      check({name, "_lo"}, lo, r.l);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{4'd1,  32'h0, 32'h0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1]  = '{4'd2,  32'h0, 32'h0, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA};
    vt[2]  = '{4'd3,  32'h0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3]  = '{4'd4,  32'h0, 32'h0, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF};
    vt[4]  = '{4'd3,  32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    vt[5]  = '{4'd8,  32'h1, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd2, 32'h0};
    vt[6]  = '{4'd9,  32'h2, 32'h0, 32'd2, 32'd3, 32'd1, 32'hFFFFFFFA};
    vt[7]  = '{4'd3,  32'h0, 32'h0, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF};
    vt[8]  = '{4'd4,  32'h0, 32'h0, 32'd100, 32'd7, 32'd2, 32'd14};
    vt[9]  = '{4'd3,  32'h0, 32'h0, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    vt[10] = '{4'd7,  32'h0, 32'd5, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd4};
    vt[11] = '{4'd10, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
    vt[12] = '{4'd1,  32'h0, 32'h0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};

    reset_n = 1'b0; mdu_op = '0; d1 = '0; d2 = '0; start = 1'b0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    for (int i = 0; i < 13; i++) begin
      mt(1'b1, vt[i].ihi);
      mt(1'b0, vt[i].ilo);
      launch(vt[i].op, vt[i].a, vt[i].b, 1'b1, vt[i].ehi, vt[i].elo);
      wait_done($sformatf("vec%0d", i), 33);
    end

    // Back-to-back: msub starts in the first idle cycle and uses the fresh maddu result.
    mt(1'b1, 32'd1);
    mt(1'b0, 32'hFFFFFFFF);
    launch(4'd8, 32'd1, 32'd1, 1'b1, 32'd2, 32'h0);
    wait_done("b2b_maddu", 33);
    launch(4'd9, 32'd2, 32'd3, 1'b1, 32'd1, 32'hFFFFFFFA);
    wait_done("b2b_msub", 33);

    // mthi and a second start while busy are both ignored.
    mt(1'b1, 32'h0);
    mt(1'b0, 32'h0);
    launch(4'd1, 32'd5, 32'd5, 1'b1, 32'h0, 32'd25);
    repeat (3) @(negedge clk);
    mdu_op = 4'd5; d1 = 32'h1234;
    @(negedge clk);
    mdu_op = 4'd1; d1 = 32'd2; d2 = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    wait_done("busy_ign", 28);
    @(negedge clk);
    check("busy_ign_nolaunch", {31'd0, busy}, 32'd0);

    // Cancel at busy cycle 10.
    mt(1'b1, 32'h0);
    mt(1'b0, 32'h0);
    launch(4'd1, 32'd5, 32'd5, 1'b0, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    check("cancel_pre_busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("cancel_hi", hi, 32'h0);
    check("cancel_lo", lo, 32'h0);

    // Cancel in the start cycle blocks the launch.
    mdu_op = 4'd2; d1 = 32'd3; d2 = 32'd3; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; mdu_op = 4'd0;
    check("cancel_start_busy", {31'd0, busy}, 32'd0);

    // Cancel in idle blocks mthi.
    mdu_op = 4'd5; d1 = 32'h55; cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0; mdu_op = 4'd0;
    check("cancel_mthi", hi, 32'h0);

    // Reserved op with start is a nop; mtlo with start does not write.
    mdu_op = 4'd12; d1 = 32'd9; d2 = 32'd9; start = 1'b1;
    @(negedge clk);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    mdu_op = 4'd6; d1 = 32'h77;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    check("mtlo_start_lo", lo, 32'h0);
    check("rsvd_hi", hi, 32'h0);

    // Reset mid-divide discards the operation.
    mt(1'b1, 32'hAAAA);
    mt(1'b0, 32'h5555);
    launch(4'd3, 32'd100, 32'd3, 1'b0, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    repeat (40) @(negedge clk);
    check("midrst_late_hi", hi, 32'h0);
    check("midrst_late_lo", lo, 32'h0);
    check("midrst_late_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
